// File: rtl/fcel_cfg_pkg.sv
// Shared constants, FSM encoding and error-code bit positions for the
// fcel configuration loader.
package fcel_cfg_pkg;

  localparam int CFG_W  = 124;
  localparam int DW     = 8;
  localparam int NWORDS = (CFG_W + DW - 1) / DW;
  localparam int PAD_W  = NWORDS * DW - CFG_W;
  localparam int CNT_W  = $clog2(NWORDS);

  localparam int ERR_CSUM = 0;
  localparam int ERR_PAD  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // The last stream word carries PAD_W unused bits that must be zero.
  function automatic logic pad_nonzero(input logic [DW-1:0] word);
    return |word[DW-1:DW-PAD_W];
  endfunction

endpackage

// File: rtl/fcel_cfg_loader.sv
// Byte-stream configuration loader: assembles a shadow frame, verifies XOR
// checksum and padding, then commits atomically onto the fcel ctrs bus.
module fcel_cfg_loader
  import fcel_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [DW-1:0]    cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [CFG_W-1:0] ctrs,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [1:0]       cfg_err_code
);

  state_e           state_q;
  logic [CFG_W-1:0] shadow_q;
  logic [CFG_W-1:0] shadow_d;
  logic [CFG_W-1:0] ctrs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    acc_q;
  logic             pad_err_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [1:0]       err_code_q;

  logic             accept_s;
  logic             last_word_s;
  logic             frame_ok_s;
  logic [1:0]       err_code_s;

  // Word acceptance and end-of-frame decode.
  always_comb begin
    accept_s    = cfg_valid & ready_q & ~cfg_start;
    last_word_s = (cnt_q == CNT_W'(NWORDS - 1));
  end

  // Shadow merge: the current word lands in its byte lane; pad bits fall off the top.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < CFG_W; i++) begin
      if ((i / DW) == int'(cnt_q)) begin
        shadow_d[i] = cfg_data[i % DW];
      end else begin
        shadow_d[i] = shadow_q[i];
      end
    end
  end

  // Frame verdict on the checksum word.
  always_comb begin
    err_code_s           = 2'b00;
    err_code_s[ERR_CSUM] = (cfg_data != acc_q);
    err_code_s[ERR_PAD]  = pad_err_q;
    frame_ok_s           = (err_code_s == 2'b00);
  end

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      ctrs_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      pad_err_q  <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            shadow_q   <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            pad_err_q  <= 1'b0;
            err_code_q <= 2'b00;
            ready_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD, ST_CHECK: begin
          if (cfg_start) begin
            // Restart: any word presented on this edge is dropped.
            shadow_q   <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            pad_err_q  <= 1'b0;
            err_code_q <= 2'b00;
            state_q    <= ST_LOAD;
          end else if (accept_s && (state_q == ST_LOAD)) begin
            shadow_q <= shadow_d;
            acc_q    <= acc_q ^ cfg_data;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last_word_s) begin
              pad_err_q <= pad_nonzero(cfg_data);
              state_q   <= ST_CHECK;
            end
          end else if (accept_s) begin
            ready_q <= 1'b0;
            if (frame_ok_s) begin
              state_q <= ST_COMMIT;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= err_code_s;
              busy_q     <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end
        end
        ST_COMMIT: begin
          ctrs_q  <= shadow_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready    = ready_q;
  assign ctrs         = ctrs_q;
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign cfg_err      = err_q;
  assign cfg_err_code = err_code_q;

endmodule

// File: tb/tb_fcel_cfg_loader.sv
// Directed scoreboard bench for fcel_cfg_loader: frames, errors, stalls,
// abort/restart and asynchronous reset.
module tb_fcel_cfg_loader;

  typedef logic [7:0] frame_t [17];
  typedef struct packed {
    logic [1:0]   kind;   // {done, err}
    logic [123:0] ctrs;
    logic [1:0]   code;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_start;
  logic [7:0]   cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [123:0] ctrs;
  logic         cfg_busy;
  logic         cfg_done;
  logic         cfg_err;
  logic [1:0]   cfg_err_code;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  fcel_cfg_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .ctrs         (ctrs),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .cfg_err_code (cfg_err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic frame_t make_frame(input logic [123:0] v);
    frame_t       fr;
    logic [127:0] wide;
    logic [7:0]   cs;
    wide = {4'b0000, v};
    cs   = 8'h00;
    for (int k = 0; k < 16; k++) begin
      fr[k] = wide[8*k +: 8];
      cs    = cs ^ fr[k];
    end
    fr[16] = cs;
    return fr;
  endfunction

  // Scoreboard: every done/err pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && (cfg_done || cfg_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {cfg_done, cfg_err}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_kind", {cfg_done, cfg_err}, e.kind);
        chk("sb_ctrs", ctrs, e.ctrs);
        chk("sb_code", cfg_err_code, e.code);
      end
    end
  end

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!cfg_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cfg_ready) chk("ready_timeout", 1'b0, 1'b1);
    cfg_data  = b;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t fr, input bit toggle, input exp_t e);
    pulse_start();
    for (int k = 0; k < 17; k++) begin
      if (k == 16) sb.push_back(e);
      send_byte(fr[k]);
      if (toggle && k < 16) begin
        cfg_data = 8'hA5;   // junk while valid is low must not be taken
        @(negedge clk);
      end
    end
  endtask

  task automatic expect_commit(input string tag, input logic [123:0] v);
    chk({tag, "_done_early"}, cfg_done, 1'b0);
    @(negedge clk);
    chk({tag, "_done"}, cfg_done, 1'b1);
    chk({tag, "_ctrs"}, ctrs, v);
    @(negedge clk);
    chk({tag, "_done_low"}, cfg_done, 1'b0);
    chk({tag, "_busy"}, cfg_busy, 1'b0);
  endtask

  task automatic expect_reject(input string tag, input logic [123:0] v, input logic [1:0] code);
    chk({tag, "_err"}, cfg_err, 1'b1);
    chk({tag, "_code"}, cfg_err_code, code);
    @(negedge clk);
    chk({tag, "_err_low"}, cfg_err, 1'b0);
    chk({tag, "_done"}, cfg_done, 1'b0);
    chk({tag, "_ctrs"}, ctrs, v);
    chk({tag, "_code_hold"}, cfg_err_code, code);
    chk({tag, "_busy"}, cfg_busy, 1'b0);
  endtask

  initial begin
    frame_t       fr;
    logic [123:0] v999;
    logic [123:0] ones;
    v999      = 124'd999;
    ones      = {124{1'b1}};
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_data  = 8'h00;
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrs", ctrs, 124'd0);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_code", cfg_err_code, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // Valid ignored in IDLE.
    cfg_valid = 1'b1;
    cfg_data  = 8'h77;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("idle_ready", cfg_ready, 1'b0);
    chk("idle_busy", cfg_busy, 1'b0);

    // 1: good frame, valid held high.
    fr = make_frame(v999);
    send_frame(fr, 1'b0, '{kind: 2'b10, ctrs: v999, code: 2'b00});
    expect_commit("t1", v999);

    // 2: checksum off by one.
    fr     = make_frame(v999);
    fr[16] = fr[16] ^ 8'h01;
    send_frame(fr, 1'b0, '{kind: 2'b01, ctrs: v999, code: 2'b01});
    expect_reject("t2", v999, 2'b01);

    // 3: nonzero pad with a matching checksum.
    fr     = make_frame(124'd0);
    fr[15] = 8'h10;
    fr[16] = 8'h10;
    send_frame(fr, 1'b0, '{kind: 2'b01, ctrs: v999, code: 2'b10});
    expect_reject("t3", v999, 2'b10);

    // 4: frame 1 with valid toggling.
    fr = make_frame(v999);
    send_frame(fr, 1'b1, '{kind: 2'b10, ctrs: v999, code: 2'b00});
    expect_commit("t4", v999);

    // 5: abort after 5 words; restart edge carries an ignored word.
    pulse_start();
    chk("t5_busy", cfg_busy, 1'b1);
    for (int k = 0; k < 5; k++) send_byte(8'h55);
    cfg_valid = 1'b1;
    cfg_data  = 8'hAA;
    pulse_start();
    cfg_valid = 1'b0;
    fr = make_frame(ones);
    for (int k = 0; k < 17; k++) begin
      if (k == 16) sb.push_back('{kind: 2'b10, ctrs: ones, code: 2'b00});
      send_byte(fr[k]);
    end
    expect_commit("t5", ones);

    // 6: asynchronous reset mid-LOAD.
    pulse_start();
    for (int k = 0; k < 3; k++) send_byte(8'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ctrs", ctrs, 124'd0);
    chk("t6_ready", cfg_ready, 1'b0);
    chk("t6_busy", cfg_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fr = make_frame(v999);
    send_frame(fr, 1'b0, '{kind: 2'b10, ctrs: v999, code: 2'b00});
    expect_commit("t6", v999);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
